// File: rtl/pkt_deframer_pkg.sv
// Shared state encoding, sync pattern and counter widths for the pkt_deframer
// serial front end and any future receivers that reuse sync_detect.
package pkt_deframer_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int          SYNC_W_DEF    = 16;
    localparam logic [15:0] SYNC_WORD_DEF = 16'hA5C3;
    localparam int          PKT_W_DEF     = 64;
    localparam int          TIMEOUT_DEF   = 255;

    // Wide enough for a trailing parity bit index as well as the payload count.
    localparam int BIT_CNT_W  = $clog2(PKT_W_DEF + 1);
    localparam int IDLE_CNT_W = $clog2(TIMEOUT_DEF + 1);

endpackage

// File: rtl/pkt_deframer_sync_detect.sv
// Sliding sync-word window: shifts valid bits in LSB-first and flags when the
// window including the bit currently presented equals the sync pattern.
module sync_detect
    import pkt_deframer_pkg::*;
#(
    parameter int              SYNC_W    = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic bit_in,
    input  logic shift_en,
    input  logic clear,
    output logic match
);

    logic [SYNC_W-1:0] window;
    logic [SYNC_W-1:0] next_window;

    assign next_window = {window[SYNC_W-2:0], bit_in};
    assign match       = shift_en && (next_window == SYNC_WORD);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            window <= '0;
        end else if (clear) begin
            window <= '0;
        end else if (shift_en) begin
            window <= next_window;
        end
    end

endmodule

// File: rtl/pkt_deframer.sv
// Sync-word hunter and 64-bit MSB-first payload deserialiser feeding the SPI CDC.
// Define PKT_PARITY_EN to require a trailing even-parity bit after the payload.
module pkt_deframer
    import pkt_deframer_pkg::*;
#(
    parameter int                SYNC_W    = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int                PKT_W     = PKT_W_DEF,
    parameter int                TIMEOUT   = TIMEOUT_DEF
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [PKT_W-1:0] shift_buf,
    output logic             pkt_rec,
    output logic             sync_lock,
    output logic             frame_err
);

`ifdef PKT_PARITY_EN
    localparam int FRAME_BITS = PKT_W + 1;
    localparam int SHADOW_W   = PKT_W;
`else
    // Without parity the final payload bit goes straight to shift_buf, so the
    // shadow only ever needs to hold the first PKT_W-1 bits.
    localparam int FRAME_BITS = PKT_W;
    localparam int SHADOW_W   = PKT_W - 1;
`endif

    localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [IDLE_CNT_W-1:0] IDLE_MAX = IDLE_CNT_W'(TIMEOUT);

    state_t                state;
    logic [SHADOW_W-1:0]   shadow;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [IDLE_CNT_W-1:0] idle_cnt;
    logic [IDLE_CNT_W-1:0] idle_next;
    logic                  sync_match;
    logic                  hunt_shift;
    logic                  timeout_hit;
    logic                  window_clear;

    assign idle_next    = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;
    assign timeout_hit  = (state == COLLECT) && !bit_valid && (idle_next == IDLE_MAX);
    assign hunt_shift   = bit_valid && (state == HUNT);
    assign window_clear = (state == DONE) || timeout_hit;

    sync_detect #(
        .SYNC_W    (SYNC_W),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync_detect (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .bit_in   (bit_in),
        .shift_en (hunt_shift),
        .clear    (window_clear),
        .match    (sync_match)
    );

    // shift_buf is written only on a good frame so the CDC always sees a settled word.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            shadow    <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            shift_buf <= '0;
            pkt_rec   <= 1'b0;
            sync_lock <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            pkt_rec   <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                HUNT: begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                    if (sync_match) begin
                        state     <= COLLECT;
                        sync_lock <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (bit_valid) begin
                        idle_cnt <= '0;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state     <= DONE;
                            sync_lock <= 1'b0;
`ifdef PKT_PARITY_EN
                            if ((^shadow) == bit_in) begin
                                shift_buf <= shadow;
                                pkt_rec   <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
`else
                            shift_buf <= {shadow, bit_in};
                            pkt_rec   <= 1'b1;
`endif
                        end else begin
                            shadow <= {shadow[SHADOW_W-2:0], bit_in};
                        end
                    end else if (timeout_hit) begin
                        state     <= HUNT;
                        sync_lock <= 1'b0;
                        frame_err <= 1'b1;
                        idle_cnt  <= idle_next;
                    end else begin
                        idle_cnt <= idle_next;
                    end
                end
                DONE: begin
                    state <= HUNT;
                end
                default: begin
                    state     <= HUNT;
                    sync_lock <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_deframer.sv
// Self-checking bench for pkt_deframer using a queue-based stream model.
// Build with PKT_PARITY_EN defined to cover the trailing parity bit.
module tb_pkt_deframer;

    localparam int          PKT_W   = 64;
    localparam int          TIMEOUT = 255;
    localparam logic [15:0] SYNC    = 16'hA5C3;
`ifdef PKT_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif
    localparam int FRAME_BITS = PKT_W + (PARITY ? 1 : 0);

    localparam int M_HUNT    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_DONE    = 2;

    logic             clk1      = 1'b0;
    logic             rst_n     = 1'b0;
    logic             bit_in    = 1'b0;
    logic             bit_valid = 1'b0;
    logic [PKT_W-1:0] shift_buf;
    logic             pkt_rec;
    logic             sync_lock;
    logic             frame_err;

    pkt_deframer dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .shift_buf (shift_buf),
        .pkt_rec   (pkt_rec),
        .sync_lock (sync_lock),
        .frame_err (frame_err)
    );

    always #5 clk1 = ~clk1;

    int checks = 0;
    int errors = 0;

    // Reference model of the framing rules.
    int          m_mode = M_HUNT;
    logic [15:0] m_win  = '0;
    bit          m_bits[$];
    int          m_idle = 0;
    logic [63:0] m_buf  = '0;
    logic        m_pkt  = 1'b0;
    logic        m_err  = 1'b0;
    logic        m_lock = 1'b0;
    int          m_pkt_cnt = 0;
    int          m_err_cnt = 0;

    // Observation tallies, cleared per scenario.
    int    cyc = 0;
    int    diffs, obs_pkt, obs_err, obs_lock, obs_pkt_cyc, obs_err_cyc;
    string first_diff;
    logic [63:0] last_good = '0;

    task automatic model_reset();
        m_mode = M_HUNT;
        m_win  = '0;
        m_bits.delete();
        m_idle = 0;
        m_buf  = '0;
        m_pkt  = 1'b0;
        m_err  = 1'b0;
        m_lock = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic b);
        logic [63:0] payload;
        bit          par;
        m_pkt = 1'b0;
        m_err = 1'b0;
        if (m_mode == M_HUNT) begin
            if (v) begin
                m_win = {m_win[14:0], b};
                if (m_win == SYNC) begin
                    m_mode = M_COLLECT;
                    m_bits.delete();
                    m_idle = 0;
                end
            end
        end else if (m_mode == M_COLLECT) begin
            if (v) begin
                m_bits.push_back(b);
                m_idle = 0;
                if (m_bits.size() == FRAME_BITS) begin
                    payload = '0;
                    for (int i = 0; i < PKT_W; i++) payload = {payload[62:0], m_bits[i]};
                    par = 1'b0;
                    foreach (m_bits[i]) par ^= m_bits[i];
                    if (!PARITY || !par) begin
                        m_buf = payload;
                        m_pkt = 1'b1;
                        m_pkt_cnt++;
                    end else begin
                        m_err = 1'b1;
                        m_err_cnt++;
                    end
                    m_mode = M_DONE;
                end
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_err  = 1'b1;
                    m_err_cnt++;
                    m_mode = M_HUNT;
                    m_win  = '0;
                end
            end
        end else begin
            m_mode = M_HUNT;
            m_win  = '0;
        end
        m_lock = (m_mode == M_COLLECT);
    endtask

    task automatic clear_obs();
        diffs = 0; obs_pkt = 0; obs_err = 0; obs_lock = 0;
        obs_pkt_cyc = -1; obs_err_cyc = -1; first_diff = "";
    endtask

    task automatic step(input logic v, input logic b);
        bit_valid = v;
        bit_in    = b;
        @(posedge clk1);
        model_step(v, b);
        cyc++;
        #1;
        if (pkt_rec !== m_pkt || frame_err !== m_err || sync_lock !== m_lock || shift_buf !== m_buf) begin
            diffs++;
            if (first_diff == "")
                first_diff = $sformatf("cyc %0d pkt %b/%b err %b/%b lock %b/%b buf %h/%h",
                                       cyc, pkt_rec, m_pkt, frame_err, m_err, sync_lock, m_lock, shift_buf, m_buf);
        end
        if (pkt_rec === 1'b1)   begin obs_pkt++; obs_pkt_cyc = cyc; end
        if (frame_err === 1'b1) begin obs_err++; obs_err_cyc = cyc; end
        if (sync_lock === 1'b1) obs_lock++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'($urandom));
    endtask

    // vmode 0: always valid, 1: invalid cycle before every valid bit, 2: random gaps
    task automatic send_word(input logic [63:0] w, input int n, input int vmode);
        for (int i = n - 1; i >= 0; i--) begin
            if (vmode == 1) step(1'b0, 1'($urandom));
            else if (vmode == 2) while ($urandom_range(3) == 0) step(1'b0, 1'($urandom));
            step(1'b1, w[i]);
        end
    endtask

    task automatic send_parity(input logic [63:0] p, input logic bad, input int vmode);
        logic pbit;
        pbit = (^p) ^ bad;
        if (PARITY) send_word(64'(pbit), 1, vmode);
    endtask

    task automatic send_packet(input logic [63:0] p, input int vmode, input logic bad);
        send_word({48'h0, SYNC}, 16, vmode);
        send_word(p, PKT_W, vmode);
        send_parity(p, bad, vmode);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk1);
        #1;
        checks++;
        if (shift_buf !== 64'h0) begin errors++; $display("[TB] FAIL reset_shift_buf: got %h want %h", shift_buf, 64'h0); end
        checks++;
        if (pkt_rec !== 1'b0) begin errors++; $display("[TB] FAIL reset_pkt_rec: got %b want 0", pkt_rec); end
        checks++;
        if (sync_lock !== 1'b0) begin errors++; $display("[TB] FAIL reset_sync_lock: got %b want 0", sync_lock); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b want 0", frame_err); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        int last;
        clear_obs();
        send_packet(64'h0123456789ABCDEF, 0, 1'b0);
        last = cyc;
        idle(3);
        last_good = 64'h0123456789ABCDEF;
        checks++;
        if (diffs !== 0) begin errors++; $display("[TB] FAIL basic_trace: %0d cycle diffs, first %s", diffs, first_diff); end
        checks++;
        if (obs_pkt !== 1) begin errors++; $display("[TB] FAIL basic_pkt_count: got %0d want 1", obs_pkt); end
        checks++;
        if (shift_buf !== 64'h0123456789ABCDEF) begin errors++; $display("[TB] FAIL basic_payload: got %h want %h", shift_buf, 64'h0123456789ABCDEF); end
        checks++;
        if (obs_lock !== FRAME_BITS) begin errors++; $display("[TB] FAIL basic_lock_cycles: got %0d want %0d", obs_lock, FRAME_BITS); end
        checks++;
        if (obs_pkt_cyc !== last) begin errors++; $display("[TB] FAIL basic_latency: got cyc %0d want %0d", obs_pkt_cyc, last); end
    endtask

    task automatic test_toggle_valid();
        int last;
        clear_obs();
        send_packet(64'h0123456789ABCDEF, 1, 1'b0);
        last = cyc;
        idle(3);
        checks++;
        if (diffs !== 0) begin errors++; $display("[TB] FAIL toggle_trace: %0d cycle diffs, first %s", diffs, first_diff); end
        checks++;
        if (obs_pkt !== 1) begin errors++; $display("[TB] FAIL toggle_pkt_count: got %0d want 1", obs_pkt); end
        checks++;
        if (shift_buf !== 64'h0123456789ABCDEF) begin errors++; $display("[TB] FAIL toggle_payload: got %h want %h", shift_buf, 64'h0123456789ABCDEF); end
        checks++;
        if (obs_pkt_cyc !== last) begin errors++; $display("[TB] FAIL toggle_latency: got cyc %0d want %0d", obs_pkt_cyc, last); end
    endtask

    task automatic test_embedded_sync();
        logic [63:0] p;
        clear_obs();
        p = {$urandom, $urandom};
        p[40:25] = SYNC;
        send_packet(p, 2, 1'b0);
        idle(3);
        last_good = p;
        checks++;
        if (diffs !== 0) begin errors++; $display("[TB] FAIL embedded_trace: %0d cycle diffs, first %s", diffs, first_diff); end
        checks++;
        if (obs_pkt !== 1) begin errors++; $display("[TB] FAIL embedded_pkt_count: got %0d want 1", obs_pkt); end
        checks++;
        if (shift_buf !== p) begin errors++; $display("[TB] FAIL embedded_payload: got %h want %h", shift_buf, p); end
    endtask

    task automatic test_timeout();
        int last;
        clear_obs();
        send_word({48'h0, SYNC}, 16, 0);
        send_word({$urandom, $urandom}, 10, 0);
        last = cyc;
        idle(TIMEOUT);
        idle(3);
        checks++;
        if (obs_err !== 1) begin errors++; $display("[TB] FAIL timeout_err_count: got %0d want 1", obs_err); end
        checks++;
        if (obs_err_cyc !== last + TIMEOUT) begin errors++; $display("[TB] FAIL timeout_err_cycle: got %0d want %0d", obs_err_cyc, last + TIMEOUT); end
        checks++;
        if (obs_pkt !== 0) begin errors++; $display("[TB] FAIL timeout_pkt_count: got %0d want 0", obs_pkt); end
        checks++;
        if (shift_buf !== last_good) begin errors++; $display("[TB] FAIL timeout_hold: got %h want %h", shift_buf, last_good); end
        checks++;
        if (sync_lock !== 1'b0) begin errors++; $display("[TB] FAIL timeout_unlock: got %b want 0", sync_lock); end
        checks++;
        if (diffs !== 0) begin errors++; $display("[TB] FAIL timeout_trace: %0d cycle diffs, first %s", diffs, first_diff); end
    endtask

    task automatic test_timeout_boundary();
        logic [63:0] p;
        clear_obs();
        p = {$urandom, $urandom};
        send_word({48'h0, SYNC}, 16, 0);
        send_word(p >> 54, 10, 0);
        idle(TIMEOUT - 1);
        send_word(p, 54, 0);
        send_parity(p, 1'b0, 0);
        idle(2);
        last_good = p;
        checks++;
        if (obs_err !== 0) begin errors++; $display("[TB] FAIL boundary_err_count: got %0d want 0", obs_err); end
        checks++;
        if (obs_pkt !== 1) begin errors++; $display("[TB] FAIL boundary_pkt_count: got %0d want 1", obs_pkt); end
        checks++;
        if (shift_buf !== p) begin errors++; $display("[TB] FAIL boundary_payload: got %h want %h", shift_buf, p); end
    endtask

    task automatic test_mid_reset();
        int rst_bad;
        clear_obs();
        rst_bad = 0;
        send_word({48'h0, SYNC}, 16, 0);
        send_word({$urandom, $urandom}, 20, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        if (shift_buf !== '0 || pkt_rec !== 1'b0 || sync_lock !== 1'b0 || frame_err !== 1'b0) rst_bad++;
        repeat (3) begin
            @(posedge clk1);
            #1;
            if (shift_buf !== '0 || pkt_rec !== 1'b0 || sync_lock !== 1'b0 || frame_err !== 1'b0) rst_bad++;
        end
        rst_n = 1'b1;
        send_packet(64'hFFFF0000FFFF0000, 0, 1'b0);
        idle(2);
        last_good = 64'hFFFF0000FFFF0000;
        checks++;
        if (rst_bad !== 0) begin errors++; $display("[TB] FAIL midreset_outputs_zero: %0d samples nonzero, want 0", rst_bad); end
        checks++;
        if (obs_err !== 0) begin errors++; $display("[TB] FAIL midreset_err_count: got %0d want 0", obs_err); end
        checks++;
        if (obs_pkt !== 1) begin errors++; $display("[TB] FAIL midreset_pkt_count: got %0d want 1", obs_pkt); end
        checks++;
        if (shift_buf !== 64'hFFFF0000FFFF0000) begin errors++; $display("[TB] FAIL midreset_payload: got %h want %h", shift_buf, 64'hFFFF0000FFFF0000); end
        checks++;
        if (diffs !== 0) begin errors++; $display("[TB] FAIL midreset_trace: %0d cycle diffs, first %s", diffs, first_diff); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] p1, p2;
        clear_obs();
        p1 = {$urandom, $urandom};
        p2 = {$urandom, $urandom};
        send_packet(p1, 0, 1'b0);
        step(1'b1, 1'($urandom));
        send_packet(p2, 0, 1'b0);
        idle(2);
        last_good = p2;
        checks++;
        if (obs_pkt !== 2) begin errors++; $display("[TB] FAIL b2b_pkt_count: got %0d want 2", obs_pkt); end
        checks++;
        if (shift_buf !== p2) begin errors++; $display("[TB] FAIL b2b_payload: got %h want %h", shift_buf, p2); end
        checks++;
        if (diffs !== 0) begin errors++; $display("[TB] FAIL b2b_trace: %0d cycle diffs, first %s", diffs, first_diff); end
    endtask

`ifdef PKT_PARITY_EN
    task automatic test_parity();
        clear_obs();
        send_packet(64'h1, 0, 1'b1);
        idle(2);
        checks++;
        if (obs_err !== 1) begin errors++; $display("[TB] FAIL parity_bad_err: got %0d want 1", obs_err); end
        checks++;
        if (obs_pkt !== 0) begin errors++; $display("[TB] FAIL parity_bad_pkt: got %0d want 0", obs_pkt); end
        checks++;
        if (shift_buf !== last_good) begin errors++; $display("[TB] FAIL parity_bad_hold: got %h want %h", shift_buf, last_good); end
        clear_obs();
        send_packet(64'h1, 0, 1'b0);
        idle(2);
        last_good = 64'h1;
        checks++;
        if (obs_pkt !== 1 || obs_err !== 0) begin errors++; $display("[TB] FAIL parity_good_pulses: got pkt %0d err %0d want 1 0", obs_pkt, obs_err); end
        checks++;
        if (shift_buf !== 64'h1) begin errors++; $display("[TB] FAIL parity_good_payload: got %h want %h", shift_buf, 64'h1); end
    endtask
`endif

    task automatic test_random();
        int pkt0, err0;
        clear_obs();
        pkt0 = m_pkt_cnt;
        err0 = m_err_cnt;
        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(20)) step(1'($urandom_range(1)), 1'($urandom));
            send_packet({$urandom, $urandom}, int'($urandom_range(2)),
                        PARITY ? 1'($urandom_range(1)) : 1'b0);
            idle($urandom_range(3));
        end
        idle(2);
        checks++;
        if (diffs !== 0) begin errors++; $display("[TB] FAIL random_trace: %0d cycle diffs, first %s", diffs, first_diff); end
        checks++;
        if (obs_pkt !== m_pkt_cnt - pkt0) begin errors++; $display("[TB] FAIL random_pkt_count: got %0d want %0d", obs_pkt, m_pkt_cnt - pkt0); end
        checks++;
        if (obs_err !== m_err_cnt - err0) begin errors++; $display("[TB] FAIL random_err_count: got %0d want %0d", obs_err, m_err_cnt - err0); end
        checks++;
        if (shift_buf !== m_buf) begin errors++; $display("[TB] FAIL random_payload: got %h want %h", shift_buf, m_buf); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle_valid();
        test_embedded_sync();
        test_timeout();
        test_timeout_boundary();
        test_mid_reset();
        test_back_to_back();
`ifdef PKT_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pkt_deframer.md
Name: pkt_deframer

Overview:
- Serial front end in the clk1 domain, directly upstream of the SPI synchroniser.
- Hunts a serial bitstream for a sync word, then deserialises the following 64-bit payload MSB-first.
- Presents the payload on shift_buf with a one-cycle pkt_rec strobe, which the synchroniser carries into the clk_SPI domain.
- Guarantees shift_buf is stable between strobes, so the downstream CDC can sample it safely.

Parameters:
- SYNC_W, 16, sync word width in bits.
- SYNC_WORD, 16'hA5C3, pattern that marks the start of a packet.
- PKT_W, 64, payload width; must match shift_buf.
- TIMEOUT, 255, maximum idle clk1 cycles without bit_valid during COLLECT before the packet is aborted.

Ports:
- clk1  in  1  system clock (1 kHz nominal).
- rst_n  in  1  asynchronous active-low reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is sampled on a clk1 rising edge only when this is high.
- shift_buf  out  PKT_W  last complete payload; bit 63 is the first payload bit received.
- pkt_rec  out  1  one-cycle strobe: shift_buf was updated this cycle.
- sync_lock  out  1  high while in COLLECT.
- frame_err  out  1  one-cycle strobe on timeout abort (and on parity fail when the optional feature is enabled).

Behaviour:
- Reset (rst_n low, async): state = HUNT; window, payload shadow and counters = 0; shift_buf = 0; pkt_rec, sync_lock and frame_err = 0.
- HUNT:
  - Each valid bit shifts into a SYNC_W-bit window, LSB in.
  - When the window, including the current bit, equals SYNC_WORD -> COLLECT on the next edge. Bit counter = 0, idle counter = 0.
- COLLECT:
  - Each valid bit shifts into a PKT_W shadow register (MSB-first) and increments the bit counter.
  - A sync-word pattern inside the payload is ignored; there is no re-hunt.
  - The idle counter increments on each cycle with bit_valid low and clears on each valid bit.
  - Idle counter reaches TIMEOUT -> frame_err pulse, clear the window, go to HUNT. shift_buf is not changed.
  - On the final payload bit -> DONE.
- DONE (one cycle):
  - shift_buf <= shadow; pkt_rec = 1 for exactly this cycle.
  - Window cleared; go to HUNT. Any bit_valid during DONE is discarded.
- Latency: pkt_rec is asserted in the cycle after the edge that samples the last payload bit.
- Throughput: shift_buf holds its value until the next pkt_rec. Minimum spacing between strobes is SYNC_W+PKT_W+1 cycles.
- sync_lock is a registered decode of state == COLLECT.
- Mid-packet reset aborts silently: no pkt_rec and no frame_err.
- Width: bit counter is $clog2(PKT_W+1) bits; idle counter is $clog2(TIMEOUT+1) bits and saturates.

Optional Feature:
- Macro: PKT_PARITY_EN.
- Defined:
  - COLLECT takes one extra trailing bit, which is even parity over the 64 payload bits.
  - On mismatch: no pkt_rec, shift_buf unchanged, frame_err pulses in the DONE cycle.
  - On match: normal DONE behaviour.
- Undefined: payload is exactly PKT_W bits; frame_err pulses on timeout only.

Decomposition:
- Package pkt_deframer_pkg holds:
  - the state enum HUNT/COLLECT/DONE;
  - the SYNC_WORD default;
  - width localparams for the bit and idle counters.
- One sub-module, sync_detect: window shift register plus comparator, with a match output. Reused by future receivers.
- FSM and payload shadow stay in the top module.

Test Plan:
- Reset release, then 0xA5C3 followed by 64 bits of 0x0123456789ABCDEF with bit_valid always high -> exactly one pkt_rec pulse, shift_buf = 0x0123456789ABCDEF, sync_lock high for exactly 64 cycles.
- Same packet with bit_valid toggling every other cycle -> identical shift_buf; pkt_rec arrives one cycle after the 64th valid bit.
- Payload containing 0xA5C3 at bits 40:25 -> no re-sync; shift_buf equals the full payload.
- Sync word, then 10 bits, then bit_valid low for 255 cycles -> frame_err pulse, no pkt_rec, shift_buf keeps its prior value, state back in HUNT.
- rst_n low for 3 cycles mid-COLLECT, then a full packet with payload 0xFFFF0000FFFF0000 -> all outputs 0 during reset, then pkt_rec with that payload.
- PKT_PARITY_EN defined, payload 0x1 with parity bit 0 -> frame_err pulse, no pkt_rec; same payload with parity bit 1 -> pkt_rec, shift_buf = 0x1.
